// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM port A arbiter: FSM states, owner ids and wait-counter type.
package mem_arb_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

   // WAIT_MIN is a 1..15 parameter; narrow it once here so callers need no casts.
   function automatic cnt_t waitLoad(input int waitMin);
      return cnt_t'(waitMin);
   endfunction

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational grant selection between fetch (I) and data (D) requesters.
// RAM_ARB_ROUND_ROBIN_EN: ties go to the requester that did not own the last grant.
module ram_arb_picker
   import mem_arb_pkg::*;
(
   input  logic i_reqI,
   input  logic i_reqD,
`ifdef RAM_ARB_ROUND_ROBIN_EN
   input  logic i_lastOwner,
`endif
   output logic o_grantValid,
   output logic o_grantOwner
);

   always_comb begin
      o_grantValid = i_reqI | i_reqD;
      o_grantOwner = i_reqD ? OWN_D : OWN_I;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (i_reqI && i_reqD) begin
         o_grantOwner = (i_lastOwner == OWN_D) ? OWN_I : OWN_D;
      end
`endif
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between instruction fetch and data load/store; all outputs registered.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of D-over-I priority.
module ram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int WAIT_MIN  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reqI,
   input  logic [BUS_WIDTH-1:0] addrI,
   output logic                 ackI,
   output logic [BUS_WIDTH-1:0] rdataI,
   input  logic                 reqD,
   input  logic                 weD,
   input  logic [BUS_WIDTH-1:0] addrD,
   input  logic [BUS_WIDTH-1:0] wdataD,
   output logic                 ackD,
   output logic [BUS_WIDTH-1:0] rdataD,
   output logic [BUS_WIDTH-1:0] memAddr,
   output logic [BUS_WIDTH-1:0] memDataIn,
   output logic                 memWriteEnable,
   input  logic [BUS_WIDTH-1:0] memOut,
   input  logic                 memBusy
);

   localparam cnt_t WAIT_LOAD = waitLoad(WAIT_MIN);

   logic [1:0] r_state;
   logic       r_owner;
   logic       r_we;
   cnt_t       r_cnt;
   logic       w_grantValid;
   logic       w_grantOwner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic       r_lastOwner;
`endif

   ram_arb_picker u_picker (
      .i_reqI       (reqI),
      .i_reqD       (reqD),
`ifdef RAM_ARB_ROUND_ROBIN_EN
      .i_lastOwner  (r_lastOwner),
`endif
      .o_grantValid (w_grantValid),
      .o_grantOwner (w_grantOwner)
   );

   // memAddr/memDataIn double as the latched request, so they are loaded at the grant
   // and simply held until the next one; write enable and acks default low every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_owner        <= OWN_I;
         r_we           <= 1'b0;
         r_cnt          <= '0;
         ackI           <= 1'b0;
         ackD           <= 1'b0;
         rdataI         <= '0;
         rdataD         <= '0;
         memAddr        <= '0;
         memDataIn      <= '0;
         memWriteEnable <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         r_lastOwner    <= OWN_D;
`endif
      end else begin
         ackI           <= 1'b0;
         ackD           <= 1'b0;
         memWriteEnable <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grantValid) begin
                  r_owner <= w_grantOwner;
                  if (w_grantOwner == OWN_D) begin
                     r_we           <= weD;
                     memAddr        <= addrD;
                     memDataIn      <= wdataD;
                     memWriteEnable <= weD;
                  end else begin
                     r_we           <= 1'b0;
                     memAddr        <= addrI;
                     memDataIn      <= '0;
                  end
`ifdef RAM_ARB_ROUND_ROBIN_EN
                  r_lastOwner <= w_grantOwner;
`endif
                  r_state <= ADDR;
               end
            end
            ADDR: begin
               r_cnt   <= WAIT_LOAD;
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (!memBusy) begin
                  if (r_owner == OWN_D) begin
                     rdataD <= r_we ? memDataIn : memOut;
                     ackD   <= 1'b1;
                  end else begin
                     rdataI <= memOut;
                     ackI   <= 1'b1;
                  end
                  r_state <= RESP;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
